// File: rtl/mode_key_debounce.sv
// rtl/mode_key_debounce.sv - two-key pushbutton debouncer producing press pulses and held levels
//
// mode_key_debounce_chan : one key's synchronizer, debounce counter and 4-state FSM
//   clk      in   system clock
//   rst      in   synchronous active-high reset
//   key_n    in   raw key, active low, asynchronous
//   pulse    out  registered one-cycle pulse on an accepted press
//   held     out  registered debounced level (1 = key held down)
//
// mode_key_debounce : two independent channels driving the mode-select stage
//   CLK      in   system clock, rising edge
//   RST      in   synchronous active-high reset
//   KEY[1:0] in   raw pushbuttons, active low (0 = pressed)
//   MODE[1:0] out one-CLK press pulse per key
//   HELD[1:0] out debounced held level per key
//
// DEBOUNCE_CYCLES must be >= 2 and 2**CNT_W must exceed DEBOUNCE_CYCLES.

module mode_key_debounce_chan #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic pulse,
    output logic held
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESS_W = 2'd1,
        ST_PRESSED = 2'd2,
        ST_REL_W   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pulse_q, pulse_d;
    logic             held_q, held_d;
    logic             pressed;

    // Synchronizer output inverted: 1 means the key is seen pressed this cycle.
    assign pressed = ~s2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            // Sync flops reset to "released" so a key held through reset
            // is treated as a fresh press once reset drops.
            s1_q    <= 1'b1;
            s2_q    <= 1'b1;
            state_q <= ST_IDLE;
            cnt_q   <= CNT_ZERO;
            pulse_q <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
            held_q  <= held_d;
        end
    end

    always_comb begin
        s1_d    = key_n;
        s2_d    = s1_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
        held_d  = held_q;

        case (state_q)
            ST_IDLE: begin
                if (pressed) begin
                    state_d = ST_PRESS_W;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = CNT_ZERO;
                end
            end

            ST_PRESS_W: begin
                if (!pressed) begin
                    // Bounce: drop back without any credit kept.
                    state_d = ST_IDLE;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_PRESSED;
                    cnt_d   = CNT_ZERO;
                    pulse_d = 1'b1;
                    held_d  = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end

            ST_PRESSED: begin
                if (!pressed) begin
                    state_d = ST_REL_W;
                    cnt_d   = CNT_ONE;
                end
            end

            ST_REL_W: begin
                if (pressed) begin
                    // Release bounce: return to PRESSED with no new pulse.
                    state_d = ST_PRESSED;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = CNT_ZERO;
                    held_d  = 1'b0;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = CNT_ZERO;
                held_d  = 1'b0;
            end
        endcase
    end

    assign pulse = pulse_q;
    assign held  = held_q;

endmodule

module mode_key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [1:0] KEY,
    output logic [1:0] MODE,
    output logic [1:0] HELD
);

    for (genvar i = 0; i < 2; i++) begin : g_key
        mode_key_debounce_chan #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_chan (
            .clk   (CLK),
            .rst   (RST),
            .key_n (KEY[i]),
            .pulse (MODE[i]),
            .held  (HELD[i])
        );
    end

endmodule

// File: tb/tb_mode_key_debounce.sv
// tb/tb_mode_key_debounce.sv - self-checking bench for mode_key_debounce

module tb_mode_key_debounce;

    localparam int DB = 8;

    logic       CLK = 1'b0;
    logic       RST;
    logic [1:0] KEY;
    logic [1:0] MODE;
    logic [1:0] HELD;

    int total = 0;
    int bad   = 0;

    mode_key_debounce #(.DEBOUNCE_CYCLES(DB), .CNT_W(4)) dut (
        .CLK  (CLK),
        .RST  (RST),
        .KEY  (KEY),
        .MODE (MODE),
        .HELD (HELD)
    );

    always #5 CLK = ~CLK;

    // Reference: a key's debounced level flips once the pressed sample
    // (raw key delayed two clocks) has disagreed with it for DB edges in a row.
    logic [1:0] m_dly0, m_dly1;
    int         m_run [2];
    logic [1:0] m_held, m_mode;

    task automatic model_edge(input logic r, input logic [1:0] k);
        logic [1:0] p;
        if (r) begin
            m_dly0 = 2'b11; m_dly1 = 2'b11;
            m_run[0] = 0; m_run[1] = 0;
            m_held = 2'b00; m_mode = 2'b00;
        end else begin
            p = ~m_dly1;
            m_mode = 2'b00;
            for (int i = 0; i < 2; i++) begin
                if (p[i] != m_held[i]) begin
                    m_run[i] = m_run[i] + 1;
                    if (m_run[i] == DB) begin
                        m_held[i] = p[i];
                        m_mode[i] = p[i];
                        m_run[i]  = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_dly1 = m_dly0;
            m_dly0 = k;
        end
    endtask

    task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic [1:0] k);
        RST = r;
        KEY = k;
        @(posedge CLK);
        model_edge(r, k);
        #1;
        chk("model_mode", MODE, m_mode);
        chk("model_held", HELD, m_held);
    endtask

    typedef struct {
        logic       rst;
        logic [1:0] key;
        int         n;
        logic [1:0] mode;
        logic [1:0] held;
    } vec_t;

    vec_t tbl [8];

    initial begin
        int pulses, at, single;
        int run_left [2];
        logic [1:0] rk;

        RST = 1'b1;
        KEY = 2'b11;
        m_dly0 = 2'b11; m_dly1 = 2'b11;
        m_run[0] = 0; m_run[1] = 0;
        m_held = 2'b00; m_mode = 2'b00;

        // Reset, clean press of KEY[0], clean release.
        tbl[0] = '{1'b1, 2'b11,  3, 2'b00, 2'b00};
        tbl[1] = '{1'b0, 2'b11, 20, 2'b00, 2'b00};
        tbl[2] = '{1'b0, 2'b10,  9, 2'b00, 2'b00};
        tbl[3] = '{1'b0, 2'b10,  1, 2'b01, 2'b01};
        tbl[4] = '{1'b0, 2'b10, 20, 2'b00, 2'b01};
        tbl[5] = '{1'b0, 2'b11,  9, 2'b00, 2'b01};
        tbl[6] = '{1'b0, 2'b11,  1, 2'b00, 2'b00};
        tbl[7] = '{1'b0, 2'b11,  5, 2'b00, 2'b00};

        for (int v = 0; v < 8; v++) begin
            for (int c = 0; c < tbl[v].n; c++) begin
                step(tbl[v].rst, tbl[v].key);
                chk("tbl_mode", MODE, tbl[v].mode);
                chk("tbl_held", HELD, tbl[v].held);
            end
        end

        // KEY[1] bounce, then stable low.
        pulses = 0; at = -1;
        for (int b = 0; b < 4; b++) begin
            for (int c = 0; c < 3; c++) begin step(1'b0, 2'b01); if (MODE[1]) pulses++; end
            for (int c = 0; c < 2; c++) begin step(1'b0, 2'b11); if (MODE[1]) pulses++; end
        end
        for (int j = 1; j <= 15; j++) begin
            step(1'b0, 2'b01);
            if (MODE[1]) begin pulses++; at = j; end
        end
        chk_int("bounce_pulses", pulses, 1);
        chk_int("bounce_latency", at, 10);
        for (int c = 0; c < 15; c++) step(1'b0, 2'b11);

        // KEY[0] release bounce from PRESSED.
        for (int c = 0; c < 15; c++) step(1'b0, 2'b10);
        chk("relb_held_start", HELD, 2'b01);
        pulses = 0; at = -1;
        for (int c = 0; c < 5; c++) begin step(1'b0, 2'b11); if (MODE[0]) pulses++; end
        for (int c = 0; c < 2; c++) begin step(1'b0, 2'b10); if (MODE[0]) pulses++; end
        chk("relb_held_mid", HELD, 2'b01);
        for (int j = 1; j <= 15; j++) begin
            step(1'b0, 2'b11);
            if (MODE[0]) pulses++;
            if (!HELD[0] && at < 0) at = j;
        end
        chk_int("relb_pulses", pulses, 0);
        chk_int("relb_fall", at, 10);

        // Simultaneous presses.
        pulses = 0; single = 0;
        for (int n = 0; n < 4; n++) begin
            for (int c = 0; c < 12; c++) begin
                step(1'b0, 2'b00);
                if (MODE == 2'b11) pulses++;
                else if (MODE != 2'b00) single++;
            end
            for (int c = 0; c < 12; c++) begin
                step(1'b0, 2'b11);
                if (MODE != 2'b00) single++;
            end
        end
        chk_int("simul_pulses", pulses, 4);
        chk_int("simul_split", single, 0);

        // Reset in the middle of debouncing KEY[0].
        pulses = 0; at = -1;
        for (int c = 0; c < 7; c++) begin step(1'b0, 2'b10); if (MODE[0]) pulses++; end
        step(1'b1, 2'b10);
        chk("rst_mid_out", {MODE, HELD}, 4'b0000);
        for (int j = 1; j <= 15; j++) begin
            step(1'b0, 2'b10);
            if (MODE[0]) begin pulses++; at = j; end
        end
        chk_int("rst_mid_pulses", pulses, 1);
        chk_int("rst_mid_latency", at, 10);
        for (int c = 0; c < 15; c++) step(1'b0, 2'b11);

        // Random keys with random hold lengths and occasional resets.
        run_left[0] = 0; run_left[1] = 0;
        rk = 2'b11;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (run_left[i] == 0) begin
                    rk[i] = ~rk[i];
                    run_left[i] = $urandom_range(1, 14);
                end
                run_left[i]--;
            end
            step(($urandom_range(0, 199) == 0), rk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
